alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle execution unit consuming the 6-bit function code produced by the ALU control stage and computing the result for the datapath. Add, sub and or complete in one cycle. Shift-left-logical runs iteratively, one bit position per cycle, so the unit does not need a barrel shifter. Operands enter through a valid/ready handshake on the issue side. The result leaves through a valid/ready handshake toward writeback.

## Interface
- `WIDTH`, default 32: operand/result width.
- `SHW`, default 5: shift-amount width; must equal clog2(`WIDTH`).
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operation offered.
- `in_ready` output 1: unit can accept an operation.
- `funct` input 6: function code from ALU control.
- `src1` input `WIDTH`: operand A (the shifted value for sll).
- `src2` input `WIDTH`: operand B.
- `shamt` input `SHW`: shift amount, used only for sll.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `result` output `WIDTH`: computed value.
- `zero` output 1: result == 0.
- `ovf` output 1: signed overflow; defined for add and sub only, 0 otherwise.
- `illegal` output 1: `funct` was not a recognised code.

## Operation
- Function codes:
  - 001001: add, src1+src2.
  - 001010: sub, src1−src2.
  - 100001: sll, src1<<shamt.
  - 100101: or, src1|src2.
  - Any other code executes as or and sets `illegal`, matching the control stage's default.
- Arithmetic is modulo 2^`WIDTH`.
- `ovf`:
  - add: operand signs are equal and the result sign differs.
  - sub: operand signs differ and the result sign differs from src1.
- States:
  - IDLE: `in_ready`=1. On `in_valid`, register the operands and code. add/sub/or/illegal compute the result and go to DONE. sll with shamt≠0 loads the shift register and counter=shamt, then goes to SHIFT. sll with shamt=0 goes to DONE with result=src1.
  - SHIFT: each cycle, shift register <<=1 with a 0 fill-in and counter−=1. When the counter reaches 1 on a shift cycle, go to DONE.
  - DONE: `out_valid`=1, and `result`/`zero`/`ovf`/`illegal` are held stable. When `out_ready`=1, go to IDLE.
- `in_ready` is 0 in SHIFT and DONE. The unit holds one operation at a time; there is no bypass from DONE to accept.
- Inputs are ignored while `in_ready`=0.
- Reset asserted mid-operation aborts the operation. State returns to IDLE and the in-flight operation is discarded with no output.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `zero`=0, `ovf`=0, `illegal`=0, state=IDLE, counter=0.
- Accept happens on the rising edge where `in_valid`&&`in_ready`.
- Latency from the accept edge to `out_valid` high:
  - add/sub/or/illegal: 1 cycle.
  - sll with shamt=0: 1 cycle.
  - sll with shamt=n, for n=1..2^`SHW`−1: 1+n cycles.
- `out_valid` stays high and outputs stay stable until the edge where `out_ready`=1.
- `in_ready` rises in the cycle after the handoff, so the minimum issue interval is 2 cycles per one-cycle operation.
- `out_ready` held high continuously gives one result per 2 cycles for add/sub/or.
- `out_ready` asserted while `out_valid`=0 has no effect.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `alu_pkg` holds:
  - the function-code localparams `FUNCT_ADD`, `FUNCT_SUB`, `FUNCT_SLL`, `FUNCT_OR`;
  - the state enum (IDLE, SHIFT, DONE).
- The ALU control stage imports the same constants, so there is a single source for the encoding.
- One sub-module, `alu_seq_shifter`: a shift register plus down-counter with load/busy/last outputs, driven by the top-level FSM.
- The add/sub/or/flag logic stays inline in the top level.

## Test plan
- Add overflow: reset, then issue add 0x7FFFFFFF+0x00000001 → `out_valid` 1 cycle after accept; result 0x80000000, `ovf`=1, `zero`=0, `illegal`=0.
- Sub to zero: sub 0x00000005−0x00000005 → result 0, `zero`=1, `ovf`=0; sub 0x80000000−1 → result 0x7FFFFFFF, `ovf`=1.
- Shift lengths: sll src1=0x00000003, shamt=4 → `in_ready`=0 for the shift cycles, `out_valid` 5 cycles after accept, result 0x00000030. Also cover shamt=0 (1 cycle, result=src1) and shamt=31 with src1=1 → 0x80000000 after 32 cycles.
- Back-pressure: `out_ready`=0 for 10 cycles after or 0xF0F00000|0x0000F0F0 → result 0xF0F0F0F0 held stable. A new `in_valid` during the stall is not accepted; it is accepted in the cycle after `out_ready` is raised.
- Illegal code: `funct`=6'b111111 with 0x00FF0000, 0x000000FF → result 0x00FF00FF, `illegal`=1; the next legal operation clears `illegal`.
- Reset mid-shift: sll shamt=20, assert `rst` after 5 cycles → immediate `in_ready`=1, `out_valid`=0, `result`=0. After deassert, no stale result appears, and a new add completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encoding for the ALU control stage and the execution unit:
// function codes and the execution-unit state enum.
package alu_pkg;

  localparam logic [5:0] FUNCT_ADD = 6'b001001;
  localparam logic [5:0] FUNCT_SUB = 6'b001010;
  localparam logic [5:0] FUNCT_SLL = 6'b100001;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_shifter.sv
// Iterative left shifter: shifts one bit per cycle while its down-counter
// is nonzero. busy means shifts remain; last marks the final shift cycle.
module alu_seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [SHW-1:0]   load_count,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             last
);

  logic [SHW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= load_value;
      count <= load_count;
    end else if (count != '0) begin
      value <= value << 1;
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);
  assign last = (count == SHW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execution unit: single-cycle add/sub/or, iterative sll,
// valid/ready handshakes on issue and writeback sides, registered outputs.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [1:0]       dbg_state
);

  import alu_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid holds with stable data until that edge, ready never
  // depends combinationally on valid.

  state_t state, next_state;

  logic             sh_load, sh_busy, sh_last;
  logic [WIDTH-1:0] sh_value, sh_next;
  logic             cap_alu, cap_shift;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_illegal;

  alu_seq_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (sh_load),
    .load_value (src1),
    .load_count (shamt),
    .value      (sh_value),
    .busy       (sh_busy),
    .last       (sh_last)
  );

  assign sum     = src1 + src2;
  assign diff    = src1 - src2;
  // Value the shifter holds after its final shift, captured on that edge.
  assign sh_next = sh_value << 1;

  always_comb begin
    alu_res     = src1 | src2;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (funct)
      FUNCT_ADD: begin
        alu_res = sum;
        alu_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
      end
      FUNCT_SUB: begin
        alu_res = diff;
        alu_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
      end
      FUNCT_SLL: alu_res = src1;  // only reached here with shamt == 0
      FUNCT_OR:  alu_res = src1 | src2;
      default:   alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    sh_load    = 1'b0;
    cap_alu    = 1'b0;
    cap_shift  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (funct == FUNCT_SLL && shamt != '0) begin
            sh_load    = 1'b1;
            next_state = ST_SHIFT;
          end else begin
            cap_alu    = 1'b1;
            next_state = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_last || !sh_busy) begin
          cap_shift  = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
    end else if (cap_alu) begin
      result  <= alu_res;
      zero    <= (alu_res == '0);
      ovf     <= alu_ovf;
      illegal <= alu_illegal;
    end else if (cap_shift) begin
      result  <= sh_next;
      zero    <= (sh_next == '0);
      ovf     <= 1'b0;
      illegal <= 1'b0;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: arithmetic flags, shift latencies,
// back-pressure, illegal codes and reset mid-shift.
module tb_alu_exec_unit;

  localparam logic [5:0] F_ADD = 6'b001001;
  localparam logic [5:0] F_SUB = 6'b001010;
  localparam logic [5:0] F_SLL = 6'b100001;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_BAD = 6'b111111;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [5:0]  funct;
  logic [31:0] src1, src2;
  logic [4:0]  shamt;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero, ovf, illegal;
  logic [1:0]  dbg_state;

  int passed = 0;
  int total  = 0;
  int lat;
  logic ir_seen, flag;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct     (funct),
    .src1      (src1),
    .src2      (src2),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Drive one operation at a negedge while idle; returns just after the accept edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s);
    in_valid = 1'b1; funct = f; src1 = a; src2 = b; shamt = s;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int l, output logic irs);
    l = 1; irs = 1'b0;
    @(negedge clk);
    while (!out_valid && l < 64) begin
      irs |= in_ready;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    funct = '0; src1 = '0; src2 = '0; shamt = '0;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero, ovf, illegal}, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // add overflow
    issue(F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    wait_out(lat, ir_seen);
    check("add_lat", lat, 1);
    check("add_result", result, 32'h8000_0000);
    check("add_flags", {zero, ovf, illegal}, 3'b010);
    check("add_state", dbg_state, 2);
    check("add_in_ready", in_ready, 0);
    take();

    // sub to zero, then sub overflow
    issue(F_SUB, 32'h0000_0005, 32'h0000_0005, 5'd0);
    wait_out(lat, ir_seen);
    check("sub0_result", result, 32'h0);
    check("sub0_flags", {zero, ovf, illegal}, 3'b100);
    take();
    issue(F_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0);
    wait_out(lat, ir_seen);
    check("subov_result", result, 32'h7FFF_FFFF);
    check("subov_flags", {zero, ovf, illegal}, 3'b010);
    take();

    // shifts
    issue(F_SLL, 32'h0000_0003, 32'hFFFF_FFFF, 5'd4);
    wait_out(lat, ir_seen);
    check("sll4_lat", lat, 5);
    check("sll4_busy", ir_seen, 0);
    check("sll4_result", result, 32'h0000_0030);
    take();
    issue(F_SLL, 32'hABCD_1234, 32'hFFFF_FFFF, 5'd0);
    wait_out(lat, ir_seen);
    check("sll0_lat", lat, 1);
    check("sll0_result", result, 32'hABCD_1234);
    take();
    issue(F_SLL, 32'h0000_0001, 32'h0, 5'd31);
    wait_out(lat, ir_seen);
    check("sll31_lat", lat, 32);
    check("sll31_result", result, 32'h8000_0000);
    check("sll31_flags", {zero, ovf, illegal}, 3'b000);
    take();
    issue(F_SLL, 32'h8000_0000, 32'h0, 5'd1);
    wait_out(lat, ir_seen);
    check("sll1_lat", lat, 2);
    check("sll1_zero", {result[0], zero}, 2'b01);
    take();

    // back-pressure with a competing request during the stall
    issue(F_OR, 32'hF0F0_0000, 32'h0000_F0F0, 5'd0);
    wait_out(lat, ir_seen);
    check("or_lat", lat, 1);
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      flag &= (result === 32'hF0F0_F0F0) && out_valid && !in_ready;
      if (i == 3) begin
        in_valid = 1'b1; funct = F_ADD; src1 = 32'd1; src2 = 32'd2; shamt = '0;
      end
      @(negedge clk);
    end
    check("stall_stable", flag, 1);
    check("stall_result", result, 32'hF0F0_F0F0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("handoff_out_valid", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("late_accept_valid", out_valid, 1);
    check("late_accept_result", result, 32'h0000_0003);
    take();

    // out_ready held high: one result per two cycles
    out_ready = 1'b1;
    @(negedge clk);
    check("early_ready_idle", {out_valid, in_ready}, 2'b01);
    issue(F_OR, 32'h0000_0001, 32'h0000_0002, 5'd0);
    @(negedge clk);
    check("stream_valid", {out_valid, result[3:0]}, 5'b1_0011);
    @(negedge clk);
    check("stream_back_idle", {out_valid, in_ready}, 2'b01);
    out_ready = 1'b0;

    // illegal code, then cleared by a legal op
    issue(F_BAD, 32'h00FF_0000, 32'h0000_00FF, 5'd0);
    wait_out(lat, ir_seen);
    check("ill_result", result, 32'h00FF_00FF);
    check("ill_flags", {zero, ovf, illegal}, 3'b001);
    take();
    issue(F_ADD, 32'h0000_0001, 32'h0000_0001, 5'd0);
    wait_out(lat, ir_seen);
    check("ill_clear_result", result, 32'h0000_0002);
    check("ill_clear_flag", illegal, 0);
    take();

    // reset mid-shift
    issue(F_SLL, 32'h0000_0001, 32'h0, 5'd20);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      flag |= out_valid;
    end
    check("no_stale_result", flag, 0);
    issue(F_ADD, 32'd10, 32'd20, 5'd0);
    wait_out(lat, ir_seen);
    check("post_rst_lat", lat, 1);
    check("post_rst_result", result, 32'd30);
    take();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
